vai_tx_arbiter: RTL

- Parametrised successor to the fixed-fan-in sub-AFU multiplexer.
- Merges NUM_SUB_AFUS downstream request channels onto one upstream request channel.
- Per-port buffering, weighted round-robin arbitration, per-port address-offset translation, per-port isolation flush and overflow detection.
- Sits between the per-AFU Tx audit stage and the manager upstream port.

---
 rtl/vai_tx_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/vai_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vai_tx_arbiter
//  Purpose  : Merges NUM_SUB_AFUS buffered request ports onto one upstream
//             channel using weighted round-robin with per-port address offset.
//  Revision : 1.0 - initial release
// ============================================================================
module vai_tx_arbiter #(
    parameter int NUM_SUB_AFUS = 16,
    parameter int ADDR_W       = 42,
    parameter int DATA_W       = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int AF_SLACK     = 4,
    parameter int WEIGHT_W     = 4,
    parameter int PORT_W       = $clog2(NUM_SUB_AFUS)
) (
    input  logic                             pClk,
    input  logic                             SoftReset_n,
    input  logic [NUM_SUB_AFUS-1:0]          afu_valid,
    input  logic [NUM_SUB_AFUS*ADDR_W-1:0]   afu_addr,
    input  logic [NUM_SUB_AFUS*DATA_W-1:0]   afu_data,
    output logic [NUM_SUB_AFUS-1:0]          afu_almFull,
    input  logic [NUM_SUB_AFUS*ADDR_W-1:0]   offset_array,
    input  logic [NUM_SUB_AFUS*WEIGHT_W-1:0] weight,
    input  logic [NUM_SUB_AFUS-1:0]          sub_reset,
    input  logic                             up_almFull,
    output logic                             up_valid,
    output logic [ADDR_W-1:0]                up_addr,
    output logic [DATA_W-1:0]                up_data,
    output logic [PORT_W-1:0]                up_port,
    output logic [NUM_SUB_AFUS-1:0]          overflow_err
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = ADDR_W + DATA_W;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_AF   = c_CNT_W'(FIFO_DEPTH - AF_SLACK);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic [NUM_SUB_AFUS-1:0] w_elig;
    logic [NUM_SUB_AFUS-1:0] w_pop;
    logic [ADDR_W-1:0]       w_head_addr [NUM_SUB_AFUS];
    logic [DATA_W-1:0]       w_head_data [NUM_SUB_AFUS];
    logic [ADDR_W-1:0]       w_offset    [NUM_SUB_AFUS];
    logic [WEIGHT_W-1:0]     w_weight    [NUM_SUB_AFUS];

    // ------------------------------------------------------------------
    // Per-port request buffers
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SUB_AFUS; gi++) begin : g_port
        logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nxt;
        logic               r_ovf;
        logic               r_af;
        logic               w_push;
        logic               w_full;
        logic               w_wr;

        assign w_push = afu_valid[gi] & ~sub_reset[gi];
        assign w_full = (r_cnt == c_CNT_FULL);
        assign w_wr   = w_push & ~w_full;

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (sub_reset[gi]) begin
                w_cnt_nxt = '0;
            end else if (w_wr && !w_pop[gi]) begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end else if (!w_wr && w_pop[gi]) begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
            end
        end

        always_ff @(posedge pClk) begin
            if (SoftReset_n && w_wr) begin
                r_mem[r_wptr] <= {afu_addr[gi*ADDR_W +: ADDR_W], afu_data[gi*DATA_W +: DATA_W]};
            end
        end

        always_ff @(posedge pClk) begin
            if (!SoftReset_n) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
                r_ovf  <= 1'b0;
                r_af   <= 1'b0;
            end else begin
                r_cnt <= w_cnt_nxt;
                r_af  <= (w_cnt_nxt >= c_CNT_AF);
                if (sub_reset[gi]) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_ovf  <= 1'b0;
                end else begin
                    if (w_wr) begin
                        r_wptr <= r_wptr + c_PTR_ONE;
                    end
                    if (w_pop[gi]) begin
                        r_rptr <= r_rptr + c_PTR_ONE;
                    end
                    // Drop decision uses pre-edge occupancy, so a same-cycle pop does not rescue it
                    if (w_push && w_full) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end

        assign w_elig[gi]      = (r_cnt != '0) & ~sub_reset[gi];
        assign w_head_addr[gi] = r_mem[r_rptr][c_ENT_W-1 -: ADDR_W];
        assign w_head_data[gi] = r_mem[r_rptr][DATA_W-1:0];
        assign w_offset[gi]    = offset_array[gi*ADDR_W +: ADDR_W];
        assign w_weight[gi]    = weight[gi*WEIGHT_W +: WEIGHT_W];
        assign afu_almFull[gi]  = r_af;
        assign overflow_err[gi] = r_ovf;
    end

    // ------------------------------------------------------------------
    // Weighted round-robin arbitration
    // ------------------------------------------------------------------
    logic [PORT_W-1:0]   r_ptr;
    logic [WEIGHT_W-1:0] r_quota;
    logic                w_hi_found;
    logic                w_lo_found;
    logic [PORT_W-1:0]   w_hi_idx;
    logic [PORT_W-1:0]   w_lo_idx;
    logic                w_keep;
    logic                w_gnt;
    logic [PORT_W-1:0]   w_gnt_port;
    logic [WEIGHT_W-1:0] w_wt;
    logic [WEIGHT_W-1:0] w_quota_load;

    // Ports above the pointer win over ports at/below it, giving ptr+1 .. ptr+N order
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int j = 0; j < NUM_SUB_AFUS; j++) begin
            if (w_elig[j] && (j > int'(r_ptr)) && !w_hi_found) begin
                w_hi_found = 1'b1;
                w_hi_idx   = PORT_W'(j);
            end
            if (w_elig[j] && (j <= int'(r_ptr)) && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = PORT_W'(j);
            end
        end
    end

    assign w_keep       = (r_quota != '0) & w_elig[r_ptr];
    assign w_gnt        = ~up_almFull & (w_keep | w_hi_found | w_lo_found);
    assign w_gnt_port   = w_keep ? r_ptr : (w_hi_found ? w_hi_idx : w_lo_idx);
    assign w_wt         = w_weight[w_gnt_port];
    assign w_quota_load = (w_wt == '0) ? '0 : (w_wt - WEIGHT_W'(1));

    always_comb begin
        w_pop = '0;
        for (int j = 0; j < NUM_SUB_AFUS; j++) begin
            w_pop[j] = w_gnt && (w_gnt_port == PORT_W'(j));
        end
    end

    // ------------------------------------------------------------------
    // Arbiter state and upstream output register
    // ------------------------------------------------------------------
    logic              r_up_valid;
    logic [ADDR_W-1:0] r_up_addr;
    logic [DATA_W-1:0] r_up_data;
    logic [PORT_W-1:0] r_up_port;

    always_ff @(posedge pClk) begin
        if (!SoftReset_n) begin
            r_ptr      <= '0;
            r_quota    <= '0;
            r_up_valid <= 1'b0;
            r_up_addr  <= '0;
            r_up_data  <= '0;
            r_up_port  <= '0;
        end else begin
            r_up_valid <= w_gnt;
            if (w_gnt) begin
                r_up_addr <= w_head_addr[w_gnt_port] + w_offset[w_gnt_port];
                r_up_data <= w_head_data[w_gnt_port];
                r_up_port <= w_gnt_port;
                if (w_keep) begin
                    r_quota <= r_quota - WEIGHT_W'(1);
                end else begin
                    r_ptr   <= w_gnt_port;
                    r_quota <= w_quota_load;
                end
            end else if (sub_reset[r_ptr]) begin
                r_quota <= '0;
            end
        end
    end

    assign up_valid = r_up_valid;
    assign up_addr  = r_up_addr;
    assign up_data  = r_up_data;
    assign up_port  = r_up_port;

endmodule
`default_nettype wire
